ntt_stage_sequencer: RTL
========================

# ntt_stage_sequencer

Control block for the in-place radix-2 NTT. Software raises `start`, and the sequencer walks all LOG_N stages of a Cooley–Tukey forward transform over a single-port-pair coefficient RAM. For each stage it issues one butterfly per cycle: read address pair plus twiddle index. It produces the matching write-back address pair after the fixed butterfly pipeline latency, and inserts inter-stage bubbles so no stage reads a coefficient before the previous stage has written it.

## Interface
Parameters:
- LOG_N, 8: log2 of transform size N (N = 256 by default); legal range 2..12.
- BF_LATENCY, 4: cycles from read address issue to write-back of the same butterfly; legal range ≥ 1.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- start  in  1  request one full transform; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the final write-back cycle.
- done  out  1  one-cycle pulse after the final write-back.
- stage  out  $clog2(LOG_N)  current stage index s, 0..LOG_N-1.
- rd_valid  out  1  rd_addr_a/b and tw_idx valid this cycle.
- rd_addr_a, rd_addr_b  out  LOG_N  butterfly operand addresses.
- tw_idx  out  LOG_N  twiddle ROM index.
- wr_valid  out  1  wr_addr_a/b valid this cycle.
- wr_addr_a, wr_addr_b  out  LOG_N  write-back addresses.

## Operation
- States:
  - IDLE → RUN on start.
  - RUN: issues N/2 butterflies. After the last one, go to GAP.
  - GAP: lasts BF_LATENCY cycles. Then go to RUN with s+1, or to DONE if s = LOG_N-1.
  - DONE: one cycle, then IDLE.
- Butterfly counter j: 0..N/2-1 within a stage; reset to 0 on entering RUN.
- Stage s span: len = 2^(LOG_N-1-s), so len = N/2 at s=0 and len = 1 at s=LOG_N-1.
- Address generation:
  - group = j >> (LOG_N-1-s)
  - off = j & (len-1)
  - rd_addr_a = group·2·len + off
  - rd_addr_b = rd_addr_a + len
  - tw_idx = 2^s + group (range 1..N-1, bit-reversed twiddle ordering)
- All arithmetic is unsigned at LOG_N bits; no wrap occurs for legal parameters.
- Write-back: wr_addr_a/b equal rd_addr_a/b delayed exactly BF_LATENCY cycles. wr_valid equals rd_valid delayed exactly BF_LATENCY cycles.
- start is ignored when not in IDLE, including the DONE cycle. A held-high start re-triggers from the first IDLE cycle.
- Reset: on RST_N low at an edge, from any state including mid-stage:
  - State becomes IDLE.
  - All outputs go to 0: busy, done, rd_valid, wr_valid, addresses, tw_idx, stage.
  - The wr_valid delay pipeline is cleared, so no stale write-back appears after reset.

## Timing
- start high in IDLE at edge t → state RUN at t+1. First rd_valid (j=0, s=0) and busy=1 are in cycle t+1.
- rd_valid is high for N/2 consecutive cycles per stage, then low for exactly BF_LATENCY cycles (GAP).
- Stage period is N/2 + BF_LATENCY cycles. Stage s begins at t+1+s·(N/2+BF_LATENCY).
- The last write of stage s occurs BF_LATENCY cycles after its last read. The first read of stage s+1 is issued the following cycle. The RAM must therefore be write-then-read visible across one edge.
- Final wr_valid is at cycle t + LOG_N·(N/2+BF_LATENCY). done=1 and busy=0 in the next cycle.
- Defaults give 1056 cycles from the first read to the last write. done is at t+1057.
- stage updates in the first RUN cycle of each stage and holds through GAP.

## Structure
- Shared package `ntt_pkg`:
  - state enum (IDLE, RUN, GAP, DONE)
  - localparams N and HALF_N derived from LOG_N
  - helper function for the stage-span shift
- Write-back address alignment instantiates the existing `delay` module: N_CYCLES = BF_LATENCY, BIT_WIDTH = 2·LOG_N.
- wr_valid uses a local resettable shift register, because `delay` has no reset.
- No other sub-modules.

## Test plan
- Reset/idle: hold RST_N low 3 cycles, then release with start=0 → all outputs 0 indefinitely.
- Defaults, start at t:
  - stage 0, j=0 → rd (0,128), tw 1
  - stage 0, j=127 → (127,255), tw 1
  - stage 1, j=64 → (128,192), tw 3
  - stage 7, j=0 → (0,1), tw 128
  - stage 7, j=127 → (254,255), tw 255
- Latency: every wr_valid/wr_addr equals rd_valid/rd_addr from exactly 4 cycles earlier. Exactly 4 rd_valid-low cycles between stages. done at t+1057; busy falls the same cycle.
- Coverage: LOG_N=4, BF_LATENCY=1. The scoreboard checks each address 0..15 is written exactly once per stage. The total is 4 stages × 9 cycles; done at t+37.
- start pulses during RUN, GAP and DONE → ignored; no restart, and the cycle counts are unchanged.
- RST_N low for one cycle mid-stage 3 → next cycle all outputs 0 and no wr_valid within the following BF_LATENCY cycles. A subsequent start reproduces the full default sequence.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT stage sequencer.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_LOG_N = 8;
  localparam int N         = 1 << DEF_LOG_N;
  localparam int HALF_N    = N / 2;

  // Right-shift that maps butterfly index j to its group at stage s.
  function automatic int span_shift(input int log_n, input int s);
    return log_n - 1 - s;
  endfunction

endpackage

// File: rtl/delay.sv
// Plain N-cycle register delay line, no reset.
// Latency N_CYCLES; no backpressure.
module delay #(
  parameter int N_CYCLES  = 1,
  parameter int BIT_WIDTH = 1
) (
  input  logic                 CLK,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  logic [BIT_WIDTH-1:0] pipe [N_CYCLES];

  always_ff @(posedge CLK) begin
    pipe[0] <= d;
    for (int i = 1; i < N_CYCLES; i++) pipe[i] <= pipe[i-1];
  end

  assign q = pipe[N_CYCLES-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Radix-2 forward NTT sequencer: one butterfly per cycle, BF_LATENCY-cycle bubble per stage.
// Write-back mirrors reads after exactly BF_LATENCY cycles; no backpressure.
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int LOG_N      = DEF_LOG_N,
  parameter int BF_LATENCY = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG_N)-1:0] stage,
  output logic                     rd_valid,
  output logic [LOG_N-1:0]         rd_addr_a,
  output logic [LOG_N-1:0]         rd_addr_b,
  output logic [LOG_N-1:0]         tw_idx,
  output logic                     wr_valid,
  output logic [LOG_N-1:0]         wr_addr_a,
  output logic [LOG_N-1:0]         wr_addr_b
);

  localparam int SW = $clog2(LOG_N);
  localparam int GW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
  localparam logic [LOG_N-1:0] J_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
  localparam logic [GW-1:0]    G_LAST = GW'(BF_LATENCY - 1);

  state_t              state;
  logic [LOG_N-1:0]    j;
  logic [SW-1:0]       s;
  logic [GW-1:0]       g;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      j     <= '0;
      s     <= '0;
      g     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          j     <= '0;
          s     <= '0;
        end
        RUN: if (j == J_LAST) begin
          state <= GAP;
          g     <= '0;
        end else begin
          j <= j + ONE;
        end
        GAP: if (g == G_LAST) begin
          if (s == S_LAST) begin
            state <= DONE;
          end else begin
            state <= RUN;
            s     <= s + 1'b1;
            j     <= '0;
          end
        end else begin
          g <= g + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [LOG_N-1:0] sh, len, grp, off, addr_a, addr_b, tw;

  always_comb begin
    sh     = LOG_N'(span_shift(LOG_N, int'(s)));
    len    = ONE << sh;
    grp    = j >> sh;
    off    = j & (len - ONE);
    addr_a = ((grp << sh) << 1) | off;
    addr_b = addr_a + len;
    tw     = (ONE << s) + grp;
  end

  // Addresses are forced to zero outside RUN so idle/reset outputs are clean.
  assign rd_valid  = (state == RUN);
  assign rd_addr_a = rd_valid ? addr_a : '0;
  assign rd_addr_b = rd_valid ? addr_b : '0;
  assign tw_idx    = rd_valid ? tw : '0;
  assign busy      = (state == RUN) || (state == GAP);
  assign done      = (state == DONE);
  assign stage     = s;

  logic [2*LOG_N-1:0]    wr_pair;
  logic [BF_LATENCY-1:0] vld_sr;

  delay #(
    .N_CYCLES  (BF_LATENCY),
    .BIT_WIDTH (2*LOG_N)
  ) u_wr_dly (
    .CLK (CLK),
    .d   ({rd_addr_a, rd_addr_b}),
    .q   (wr_pair)
  );

  // The address delay line has no reset, so validity is tracked separately.
  always_ff @(posedge CLK) begin
    if (!RST_N) vld_sr <= '0;
    else        vld_sr <= (vld_sr << 1) | BF_LATENCY'(rd_valid);
  end

  assign wr_valid  = vld_sr[BF_LATENCY-1];
  assign wr_addr_a = wr_valid ? wr_pair[2*LOG_N-1:LOG_N] : '0;
  assign wr_addr_b = wr_valid ? wr_pair[LOG_N-1:0] : '0;

endmodule
